// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: opcodes, tipo codes, imm formats and queue entry
// shared by the fetch stage and its instruction queue.
package instruction_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] TIPO_LW  = 3'b000;
  localparam logic [2:0] TIPO_SW  = 3'b010;
  localparam logic [2:0] TIPO_R   = 3'b011;
  localparam logic [2:0] TIPO_BEQ = 3'b110;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] op);
    imm_fmt_of = IMM_NONE;
    unique case (1'b1)
      op == OP_LW:  imm_fmt_of = IMM_I;
      op == OP_SW:  imm_fmt_of = IMM_S;
      op == OP_BEQ: imm_fmt_of = IMM_B;
      default:      imm_fmt_of = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: DEPTH-entry FIFO of {pc, inst} with flush;
// DEPTH must be a power of two so the pointers wrap naturally.
module ifetch_queue
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fq_entry_t     wdata,
  output fq_entry_t     rdata,
  output logic          empty,
  output logic [CW-1:0] count
);

  fq_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;

  // storage is write-only state; no reset needed
  always_ff @(posedge clock) begin
    if (push && !flush && !reset) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // pointers and occupancy; flush drops everything
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, issue, epoch-tagged capture and field decode.
// Optional illegal-opcode halt: define IFETCH_ILLEGAL_TRAP_EN.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst,
  output logic [2:0]  tipo,
  output logic [2:0]  funct3,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        illegal
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            epoch_q, epoch_d;
  logic            halted_q, halted_d;
  logic            infl_q;
  logic            infl_ep_q;
  logic [XLEN-1:0] infl_pc_q;

  fq_entry_t       head;
  logic            q_empty;
  logic [CW-1:0]   q_count;
  logic [CW:0]     occ;
  logic            pop;
  logic            issue;
  logic            capture;
  logic [6:0]      opcode;
  imm_fmt_e        fmt;

  assign inst_valid = !reset && !q_empty && !branch_taken;
  assign pop        = inst_valid && inst_ready;
  // words queued plus in flight, minus the one leaving now
  assign occ   = {1'b0, q_count} + (CW + 1)'(infl_q) - (CW + 1)'(pop);
  assign issue = !reset && !branch_taken && !halted_q
              && (occ < (CW + 1)'(DEPTH));
  assign capture = infl_q && (infl_ep_q == epoch_q) && !branch_taken;

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  ifetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clock (clock),
    .reset (reset),
    .flush (branch_taken),
    .push  (capture),
    .pop   (pop),
    .wdata ('{pc: infl_pc_q, inst: imem_rdata}),
    .rdata (head),
    .empty (q_empty),
    .count (q_count)
  );

  assign opcode = head.inst[6:0];
  assign fmt    = imm_fmt_of(opcode);

`ifdef IFETCH_ILLEGAL_TRAP_EN
  logic supported;
  assign supported = (opcode == OP_LW) || (opcode == OP_SW)
                  || (opcode == OP_R)  || (opcode == OP_BEQ);
  assign illegal = inst_valid && !supported;
`else
  assign illegal = 1'b0;
`endif

  // field decode of the queue head, zeroed while nothing is presented
  always_comb begin
    inst_pc = '0;
    inst    = '0;
    tipo    = '0;
    funct3  = '0;
    rd      = '0;
    rs1     = '0;
    rs2     = '0;
    imm     = '0;
    if (inst_valid) begin
      inst_pc = head.pc;
      inst    = head.inst;
      tipo    = opcode[6:4];
      funct3  = head.inst[14:12];
      rd      = head.inst[11:7];
      rs1     = head.inst[19:15];
      rs2     = head.inst[24:20];
      case (fmt)
        IMM_I: imm = {{20{head.inst[31]}}, head.inst[31:20]};
        IMM_S: imm = {{20{head.inst[31]}}, head.inst[31:25],
                      head.inst[11:7]};
        IMM_B: imm = {{19{head.inst[31]}}, head.inst[31],
                      head.inst[7], head.inst[30:25],
                      head.inst[11:8], 1'b0};
        default: imm = '0;
      endcase
    end
  end

  // next PC / epoch / halt; redirect wins over issue and pop
  always_comb begin
    pc_d     = pc_q;
    epoch_d  = epoch_q;
    halted_d = halted_q;
    if (branch_taken) begin
      pc_d     = branch_target;
      epoch_d  = ~epoch_q;
      halted_d = 1'b0;
    end else begin
      if (issue) pc_d = pc_q + 32'd4;
`ifdef IFETCH_ILLEGAL_TRAP_EN
      if (pop && illegal) halted_d = 1'b1;
`endif
    end
  end

  // state update; reset overrides a same-cycle redirect
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      epoch_q   <= 1'b0;
      halted_q  <= 1'b0;
      infl_q    <= 1'b0;
      infl_ep_q <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      epoch_q   <= epoch_d;
      halted_q  <= halted_d;
      infl_q    <= issue;
      infl_ep_q <= epoch_q;
      infl_pc_q <= pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus with a scoreboard queue of
// expected transfers and a negedge monitor that pops and compares.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic [2:0]  tipo;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        illegal;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  tipo;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  instruction_fetch dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_pc       (inst_pc),
    .inst          (inst),
    .tipo          (tipo),
    .funct3        (funct3),
    .rd            (rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .imm           (imm),
    .illegal       (illegal)
  );

  always #5 clock = ~clock;

  // program image with hand-decoded fields
  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.ill = 1'b0;
    case (pc)
      32'h0: begin
        e.inst = 32'h00402083; e.tipo = 3'b000; e.f3 = 3'd2;
        e.rd = 5'd1; e.rs1 = 5'd0; e.rs2 = 5'd4; e.imm = 32'd4;
      end
      32'h4: begin
        e.inst = 32'hFE20AC23; e.tipo = 3'b010; e.f3 = 3'd2;
        e.rd = 5'd24; e.rs1 = 5'd1; e.rs2 = 5'd2;
        e.imm = 32'hFFFF_FFF8;
      end
      32'h8: begin
        e.inst = 32'h002081B3; e.tipo = 3'b011; e.f3 = 3'd0;
        e.rd = 5'd3; e.rs1 = 5'd1; e.rs2 = 5'd2; e.imm = 32'd0;
      end
      32'hC: begin
        e.inst = 32'h00208463; e.tipo = 3'b110; e.f3 = 3'd0;
        e.rd = 5'd8; e.rs1 = 5'd1; e.rs2 = 5'd2; e.imm = 32'd8;
      end
      32'h40: begin
        e.inst = 32'hFFF12283; e.tipo = 3'b000; e.f3 = 3'd2;
        e.rd = 5'd5; e.rs1 = 5'd2; e.rs2 = 5'd31;
        e.imm = 32'hFFFF_FFFF;
      end
      32'h100: begin
        e.inst = 32'h00000013; e.tipo = 3'b001; e.f3 = 3'd0;
        e.rd = 5'd0; e.rs1 = 5'd0; e.rs2 = 5'd0; e.imm = 32'd0;
`ifdef IFETCH_ILLEGAL_TRAP_EN
        e.ill = 1'b1;
`endif
      end
      default: begin
        e.inst = 32'h33 | ({27'd0, pc[6:2]} << 7);
        e.tipo = 3'b011; e.f3 = 3'd0; e.rd = pc[6:2];
        e.rs1 = 5'd0; e.rs2 = 5'd0; e.imm = 32'd0;
      end
    endcase
    return e;
  endfunction

  // synchronous memory, one-cycle read latency
  always @(posedge clock) begin
    if (imem_req) imem_rdata <= mk(imem_addr).inst;
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    sb.push_back(mk(pc));
  endtask

  // monitor: every transfer must match the oldest expectation
  always @(negedge clock) begin
    if (!reset && inst_valid && inst_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_xfer: got pc %h expected none",
                 inst_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("xfer_pc", inst_pc, e.pc);
        chk("xfer_inst", inst, e.inst);
        chk("xfer_tipo", 32'(tipo), 32'(e.tipo));
        chk("xfer_funct3", 32'(funct3), 32'(e.f3));
        chk("xfer_rd", 32'(rd), 32'(e.rd));
        chk("xfer_rs1", 32'(rs1), 32'(e.rs1));
        chk("xfer_rs2", 32'(rs2), 32'(e.rs2));
        chk("xfer_imm", imm, e.imm);
        chk("xfer_illegal", 32'(illegal), 32'(e.ill));
      end
    end
  end

  initial begin
    reset = 1'b1;
    inst_ready = 1'b1;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 60; c++) begin
      inst_ready = !((c >= 10 && c <= 19) || c == 24 || c == 25
                     || c >= 56);
      branch_taken = (c == 26 || c == 33 || c == 42 || c == 51);
      case (c)
        26: branch_target = 32'h40;
        33: branch_target = 32'hFFFF_FFF8;
        42: branch_target = 32'h100;
        default: branch_target = 32'h0;
      endcase
      case (c)
        0: for (int k = 0; k < 12; k++) push_exp(32'(k * 4));
        27: for (int k = 0; k < 4; k++) push_exp(32'h40 + 32'(k * 4));
        34: for (int k = 0; k < 6; k++)
              push_exp(32'hFFFF_FFF8 + 32'(k * 4));
`ifdef IFETCH_ILLEGAL_TRAP_EN
        43: for (int k = 0; k < 3; k++) push_exp(32'h100 + 32'(k * 4));
`else
        43: for (int k = 0; k < 6; k++) push_exp(32'h100 + 32'(k * 4));
`endif
        52: begin push_exp(32'h0); push_exp(32'h4); end
        default: ;
      endcase
      @(negedge clock);
      case (c)
        0: begin
          chk("c0_req", 32'(imem_req), 32'd1);
          chk("c0_addr", imem_addr, 32'h0);
          chk("c0_valid", 32'(inst_valid), 32'd0);
        end
        1: begin
          chk("c1_addr", imem_addr, 32'h4);
          chk("c1_valid", 32'(inst_valid), 32'd0);
        end
        2: chk("c2_valid", 32'(inst_valid), 32'd1);
        5: chk("stream_req", 32'(imem_req), 32'd1);
        20: begin
          chk("release_req", 32'(imem_req), 32'd1);
          chk("release_addr", imem_addr, 32'h28);
        end
        26: begin
          chk("redir_valid", 32'(inst_valid), 32'd0);
          chk("redir_req", 32'(imem_req), 32'd0);
        end
        27: begin
          chk("target_req", 32'(imem_req), 32'd1);
          chk("target_addr", imem_addr, 32'h40);
        end
        28: chk("r2_valid", 32'(inst_valid), 32'd0);
        29: begin
          chk("r3_valid", 32'(inst_valid), 32'd1);
          chk("r3_pc", inst_pc, 32'h40);
        end
        36: begin
          chk("wrap_req", 32'(imem_req), 32'd1);
          chk("wrap_addr", imem_addr, 32'h0);
        end
`ifdef IFETCH_ILLEGAL_TRAP_EN
        46, 47: chk("halt_req", 32'(imem_req), 32'd0);
        48, 49, 50: begin
          chk("halt_req", 32'(imem_req), 32'd0);
          chk("halt_valid", 32'(inst_valid), 32'd0);
        end
`else
        47: begin
          chk("nohalt_req", 32'(imem_req), 32'd1);
          chk("nohalt_addr", imem_addr, 32'h110);
        end
`endif
        52: begin
          chk("resume_req", 32'(imem_req), 32'd1);
          chk("resume_addr", imem_addr, 32'h0);
        end
        54: begin
          chk("resume_valid", 32'(inst_valid), 32'd1);
          chk("resume_pc", inst_pc, 32'h0);
        end
        default:
          if (c >= 10 && c <= 19)
            chk("bp_req", 32'(imem_req), 32'd0);
      endcase
      @(posedge clock);
      #1;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
